// File: rtl/stream_dispatch_ctrl_pkg.sv
// Shared definitions for the stream dispatch controller: opcodes, header
// field positions and the FSM state encoding.
package stream_dispatch_ctrl_pkg;

    localparam logic [7:0] OP_WGT   = 8'd0;
    localparam logic [7:0] OP_IFM   = 8'd1;
    localparam logic [7:0] OP_BIAS  = 8'd2;
    localparam logic [7:0] OP_START = 8'd3;

    localparam int HDR_OPC_LSB  = 0;
    localparam int HDR_OPC_W    = 8;
    localparam int HDR_CNT_LSB  = 16;
    localparam int HDR_CNT_W    = 16;
    localparam int HDR_BASE_LSB = 32;

    localparam int NUM_DEST = 3;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    function automatic logic is_load_op(input logic [7:0] opc);
        return opc <= OP_BIAS;
    endfunction

endpackage

// File: rtl/dispatch_addr_gen.sv
// Payload address generator: latches base and word count from a header and
// produces base+index (wrapping) plus a last-word flag for the FSM.
module dispatch_addr_gen
    import stream_dispatch_ctrl_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic                 load,
    input  logic                 advance,
    input  logic [ADDR_W-1:0]    base_in,
    input  logic [HDR_CNT_W-1:0] count_in,
    output logic [ADDR_W-1:0]    addr,
    output logic                 last_word
);

    logic [ADDR_W-1:0]    base_reg;
    logic [HDR_CNT_W-1:0] count_reg;
    logic [HDR_CNT_W-1:0] idx_reg;

    always_ff @(posedge clk) begin
        if (!aresetn) begin
            base_reg  <= '0;
            count_reg <= '0;
            idx_reg   <= '0;
        end else if (load) begin
            base_reg  <= base_in;
            count_reg <= count_in;
            idx_reg   <= '0;
        end else if (advance) begin
            idx_reg <= idx_reg + HDR_CNT_W'(1);
        end
    end

    // Truncation to ADDR_W gives the modulo-2^ADDR_W wrap.
    assign addr      = base_reg + ADDR_W'(idx_reg);
    assign last_word = (idx_reg == count_reg - HDR_CNT_W'(1));

endmodule

// File: rtl/stream_dispatch_ctrl.sv
// Header-driven stream dispatcher: routes payload words into weight/ifmap/bias
// buffers and hands off start/done with the conv core.
module stream_dispatch_ctrl
    import stream_dispatch_ctrl_pkg::*;
#(
    parameter int TBITS  = 64,
    parameter int ADDR_W = 12
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [TBITS-1:0]  isif_data_dout,
    input  logic              isif_last_dout,
    input  logic              isif_empty_n,
    output logic              isif_read,
    output logic [2:0]        buf_wr_en,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic [TBITS-1:0]  buf_wr_data,
    output logic              core_start,
    input  logic              core_done,
    output logic              busy,
    output logic              err
);

    state_t state_reg, state_next;
    logic   ready_reg;
    logic   err_reg, err_next;
    logic [1:0] dest_reg, dest_next;

    logic                 consume;
    logic                 hdr_load;
    logic                 wr_active;
    logic                 last_word;
    logic [7:0]           opc;
    logic [HDR_CNT_W-1:0] hdr_cnt;
    logic [ADDR_W-1:0]    hdr_base;
    logic [ADDR_W-1:0]    gen_addr;
    logic                 can_pop;

    assign opc      = isif_data_dout[HDR_OPC_LSB +: HDR_OPC_W];
    assign hdr_cnt  = isif_data_dout[HDR_CNT_LSB +: HDR_CNT_W];
    assign hdr_base = isif_data_dout[HDR_BASE_LSB +: ADDR_W];

    // ready_reg holds off popping for the first cycle after reset release;
    // aresetn gating keeps a word from being popped or written at a reset edge.
    assign can_pop = ready_reg && aresetn && isif_empty_n;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg <= ST_HDR;
            ready_reg <= 1'b0;
            err_reg   <= 1'b0;
            dest_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ready_reg <= 1'b1;
            err_reg   <= err_next;
            dest_reg  <= dest_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        err_next   = err_reg;
        dest_next  = dest_reg;
        consume    = 1'b0;
        hdr_load   = 1'b0;
        wr_active  = 1'b0;
        core_start = 1'b0;
        case (state_reg)
            ST_HDR: begin
                consume = can_pop;
                if (consume) begin
                    if (isif_last_dout)
                        err_next = 1'b1;
                    if (is_load_op(opc)) begin
                        if (hdr_cnt != '0) begin
                            dest_next  = opc[1:0];
                            hdr_load   = 1'b1;
                            state_next = ST_LOAD;
                        end
                    end else if (opc == OP_START) begin
                        state_next = ST_RUN;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                consume = can_pop;
                if (consume) begin
                    wr_active = 1'b1;
                    if (last_word) begin
                        if (!isif_last_dout)
                            err_next = 1'b1;
                        state_next = ST_HDR;
                    end else if (isif_last_dout) begin
                        err_next   = 1'b1;
                        state_next = ST_HDR;
                    end
                end
            end
            ST_RUN: begin
                core_start = aresetn;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done)
                    state_next = ST_HDR;
            end
            default: state_next = ST_HDR;
        endcase
    end

    dispatch_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (aclk),
        .aresetn   (aresetn),
        .load      (hdr_load),
        .advance   (wr_active),
        .base_in   (hdr_base),
        .count_in  (hdr_cnt),
        .addr      (gen_addr),
        .last_word (last_word)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DEST; gi++) begin : g_wr_en
            assign buf_wr_en[gi] = wr_active && (dest_reg == 2'(gi));
        end
    endgenerate

    assign isif_read   = consume;
    assign buf_wr_addr = wr_active ? gen_addr : '0;
    assign buf_wr_data = wr_active ? isif_data_dout : '0;
    assign busy        = (state_reg != ST_HDR);
    assign err         = err_reg;

endmodule

// File: tb/tb_stream_dispatch_ctrl.sv
// Directed bench for stream_dispatch_ctrl: one task per scenario, each with
// hand-computed expectations.
module tb_stream_dispatch_ctrl;

    localparam int TBITS  = 64;
    localparam int ADDR_W = 12;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [TBITS-1:0]  isif_data_dout;
    logic              isif_last_dout;
    logic              isif_empty_n;
    logic              isif_read;
    logic [2:0]        buf_wr_en;
    logic [ADDR_W-1:0] buf_wr_addr;
    logic [TBITS-1:0]  buf_wr_data;
    logic              core_start;
    logic              core_done;
    logic              busy;
    logic              err;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    stream_dispatch_ctrl #(.TBITS(TBITS), .ADDR_W(ADDR_W)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .isif_data_dout (isif_data_dout),
        .isif_last_dout (isif_last_dout),
        .isif_empty_n   (isif_empty_n),
        .isif_read      (isif_read),
        .buf_wr_en      (buf_wr_en),
        .buf_wr_addr    (buf_wr_addr),
        .buf_wr_data    (buf_wr_data),
        .core_start     (core_start),
        .core_done      (core_done),
        .busy           (busy),
        .err            (err)
    );

    function automatic logic [63:0] hdr(input logic [7:0] op, input logic [15:0] n,
                                        input logic [11:0] base);
        return {20'h0, base, n, 8'h00, op};
    endfunction

    task automatic next_cycle();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input logic [63:0] d, input logic last, input logic vld);
        isif_data_dout = d;
        isif_last_dout = last;
        isif_empty_n   = vld;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        drive(hdr(8'd0, 16'd1, 12'h0), 1'b0, 1'b1);
        core_done = 1'b0;
        @(posedge aclk);
        @(posedge aclk);
        @(negedge aclk);
        checks++;
        if ({isif_read, buf_wr_en, core_start, busy, err} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got rd=%b en=%b st=%b busy=%b err=%b need all 0",
                     isif_read, buf_wr_en, core_start, busy, err);
        end
        checks++;
        if (buf_wr_addr !== 12'h0 || buf_wr_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_bus got addr=%h data=%h need 0", buf_wr_addr, buf_wr_data);
        end
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        checks++;
        if (isif_read !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_cycle got rd=%b need 0", isif_read);
        end
        isif_empty_n = 1'b0;
        next_cycle();
        $display("reset: done");
    endtask

    task automatic test_weight_load();
        drive(hdr(8'd0, 16'd4, 12'h010), 1'b0, 1'b1);
        @(negedge aclk);
        checks++;
        if (isif_read !== 1'b1 || buf_wr_en !== 3'b000) begin
            errors++;
            $display("FAIL wgt_hdr got rd=%b en=%b need 1 000", isif_read, buf_wr_en);
        end
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            drive(64'hA000 + 64'(k), (k == 3), 1'b1);
            @(negedge aclk);
            checks++;
            if (buf_wr_en !== 3'b001 || buf_wr_addr !== 12'(12'h010 + k) ||
                buf_wr_data !== 64'hA000 + 64'(k)) begin
                errors++;
                $display("FAIL wgt_word%0d got en=%b addr=%h data=%h need 001 %h %h",
                         k, buf_wr_en, buf_wr_addr, buf_wr_data, 12'(12'h010 + k), 64'hA000 + 64'(k));
            end
            next_cycle();
        end
        isif_empty_n = 1'b0;
        @(negedge aclk);
        checks++;
        if ({busy, err, buf_wr_en} !== 5'b0) begin
            errors++;
            $display("FAIL wgt_end got busy=%b err=%b en=%b need 0 0 000", busy, err, buf_wr_en);
        end
        next_cycle();
        $display("weight_load: done");
    endtask

    task automatic test_wrap();
        logic [11:0] exp_addr [3];
        exp_addr[0] = 12'hFFE;
        exp_addr[1] = 12'hFFF;
        exp_addr[2] = 12'h000;
        drive(hdr(8'd1, 16'd3, 12'hFFE), 1'b0, 1'b1);
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                for (int g = 0; g < 2; g++) begin
                    drive(64'hDEAD, 1'b0, 1'b0);
                    @(negedge aclk);
                    checks++;
                    if (buf_wr_en !== 3'b000 || isif_read !== 1'b0 || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL wrap_gap%0d got en=%b rd=%b busy=%b need 000 0 1",
                                 g, buf_wr_en, isif_read, busy);
                    end
                    next_cycle();
                end
            end
            drive(64'hB000 + 64'(k), (k == 2), 1'b1);
            @(negedge aclk);
            checks++;
            if (buf_wr_en !== 3'b010 || buf_wr_addr !== exp_addr[k]) begin
                errors++;
                $display("FAIL wrap_word%0d got en=%b addr=%h need 010 %h",
                         k, buf_wr_en, buf_wr_addr, exp_addr[k]);
            end
            next_cycle();
        end
        isif_empty_n = 1'b0;
        @(negedge aclk);
        checks++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end got busy=%b err=%b need 0 0", busy, err);
        end
        next_cycle();
        $display("wrap: done");
    endtask

    task automatic test_start();
        drive(hdr(8'd3, 16'd0, 12'h0), 1'b0, 1'b1);
        next_cycle();
        drive(hdr(8'd0, 16'd0, 12'h0), 1'b0, 1'b1);
        @(negedge aclk);
        checks++;
        if (core_start !== 1'b1 || busy !== 1'b1 || isif_read !== 1'b0) begin
            errors++;
            $display("FAIL start_run got st=%b busy=%b rd=%b need 1 1 0", core_start, busy, isif_read);
        end
        next_cycle();
        for (int i = 1; i <= 5; i++) begin
            core_done = (i == 5);
            @(negedge aclk);
            checks++;
            if (core_start !== 1'b0 || busy !== 1'b1 || isif_read !== 1'b0) begin
                errors++;
                $display("FAIL start_wait%0d got st=%b busy=%b rd=%b need 0 1 0",
                         i, core_start, busy, isif_read);
            end
            next_cycle();
        end
        core_done = 1'b0;
        @(negedge aclk);
        checks++;
        if (busy !== 1'b0 || isif_read !== 1'b1 || buf_wr_en !== 3'b000) begin
            errors++;
            $display("FAIL start_back_hdr got busy=%b rd=%b en=%b need 0 1 000",
                     busy, isif_read, buf_wr_en);
        end
        next_cycle();
        isif_empty_n = 1'b0;
        core_done = 1'b1;
        @(negedge aclk);
        next_cycle();
        core_done = 1'b0;
        @(negedge aclk);
        checks++;
        if (busy !== 1'b0 || core_start !== 1'b0) begin
            errors++;
            $display("FAIL start_stray_done got busy=%b st=%b need 0 0", busy, core_start);
        end
        next_cycle();
        $display("start: done");
    endtask

    task automatic test_n_zero();
        drive(hdr(8'd2, 16'd0, 12'h050), 1'b0, 1'b1);
        @(negedge aclk);
        checks++;
        if (isif_read !== 1'b1 || buf_wr_en !== 3'b000) begin
            errors++;
            $display("FAIL nzero_hdr got rd=%b en=%b need 1 000", isif_read, buf_wr_en);
        end
        next_cycle();
        drive(hdr(8'd0, 16'd0, 12'h060), 1'b0, 1'b1);
        @(negedge aclk);
        checks++;
        if (busy !== 1'b0 || buf_wr_en !== 3'b000 || err !== 1'b0) begin
            errors++;
            $display("FAIL nzero_stay got busy=%b en=%b err=%b need 0 000 0", busy, buf_wr_en, err);
        end
        next_cycle();
        isif_empty_n = 1'b0;
        next_cycle();
        $display("n_zero: done");
    endtask

    task automatic test_bad_opcode();
        drive(hdr(8'd7, 16'd2, 12'h070), 1'b0, 1'b1);
        next_cycle();
        isif_empty_n = 1'b0;
        @(negedge aclk);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bad_opcode got err=%b busy=%b need 1 0", err, busy);
        end
        next_cycle();
        $display("bad_opcode: done");
    endtask

    task automatic test_reset_mid_load();
        drive(hdr(8'd0, 16'd4, 12'h300), 1'b0, 1'b1);
        next_cycle();
        drive(64'hC000, 1'b0, 1'b1);
        @(negedge aclk);
        checks++;
        if (buf_wr_en !== 3'b001 || buf_wr_addr !== 12'h300) begin
            errors++;
            $display("FAIL rstld_word0 got en=%b addr=%h need 001 300", buf_wr_en, buf_wr_addr);
        end
        next_cycle();
        drive(64'hC001, 1'b0, 1'b1);
        aresetn = 1'b0;
        next_cycle();
        @(negedge aclk);
        checks++;
        if ({isif_read, buf_wr_en, core_start, busy, err} !== 7'b0 ||
            buf_wr_addr !== 12'h0 || buf_wr_data !== 64'h0) begin
            errors++;
            $display("FAIL rstld_outputs got rd=%b en=%b st=%b busy=%b err=%b addr=%h data=%h need all 0",
                     isif_read, buf_wr_en, core_start, busy, err, buf_wr_addr, buf_wr_data);
        end
        next_cycle();
        aresetn = 1'b1;
        @(negedge aclk);
        checks++;
        if (isif_read !== 1'b0 || buf_wr_en !== 3'b000) begin
            errors++;
            $display("FAIL rstld_first_cycle got rd=%b en=%b need 0 000", isif_read, buf_wr_en);
        end
        isif_empty_n = 1'b0;
        next_cycle();
        $display("reset_mid_load: done");
    endtask

    task automatic test_early_tlast();
        drive(hdr(8'd2, 16'd8, 12'h100), 1'b0, 1'b1);
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            drive(64'hE000 + 64'(k), (k == 2), 1'b1);
            @(negedge aclk);
            checks++;
            if (buf_wr_en !== 3'b100 || buf_wr_addr !== 12'(12'h100 + k)) begin
                errors++;
                $display("FAIL early_word%0d got en=%b addr=%h need 100 %h",
                         k, buf_wr_en, buf_wr_addr, 12'(12'h100 + k));
            end
            next_cycle();
        end
        drive(hdr(8'd0, 16'd1, 12'h200), 1'b0, 1'b1);
        @(negedge aclk);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || buf_wr_en !== 3'b000) begin
            errors++;
            $display("FAIL early_hdr got err=%b busy=%b en=%b need 1 0 000", err, busy, buf_wr_en);
        end
        next_cycle();
        drive(64'hF00D, 1'b1, 1'b1);
        @(negedge aclk);
        checks++;
        if (buf_wr_en !== 3'b001 || buf_wr_addr !== 12'h200 || buf_wr_data !== 64'hF00D) begin
            errors++;
            $display("FAIL early_next got en=%b addr=%h data=%h need 001 200 f00d",
                     buf_wr_en, buf_wr_addr, buf_wr_data);
        end
        next_cycle();
        isif_empty_n = 1'b0;
        next_cycle();
        $display("early_tlast: done");
    endtask

    initial begin
        test_reset();
        test_weight_load();
        test_wrap();
        test_start();
        test_n_zero();
        test_bad_opcode();
        test_reset_mid_load();
        test_early_tlast();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
